branch_resolver: RTL and testbench

- ID-stage companion to the instruction fetch unit.
- Registers the fetched instruction into the IF/ID register and decodes branches: B, B.cond, CBZ.
- Drives the fetch unit's imm26, imm19, uncondBr and brTaken inputs back to it.
- Keeps the architectural NZCV flag register, stalls fetch while a CBZ operand is unavailable, and counts taken branches.
- Branch target is relative to the ID-stage PC. The instruction in the slot after a branch always executes (one delay slot).

---
 rtl/branch_pkg.sv | 16 +
 rtl/branch_resolver_if.sv | 24 ++
 rtl/branch_resolver_cond_eval.sv | 22 ++
 rtl/branch_resolver.sv | 69 ++++++
 tb/tb_branch_resolver.sv | 108 ++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared opcodes, condition codes, flag layout and FSM states for branch resolution
package branch_pkg;
   localparam logic [5:0] OP_B     = 6'b000101;
   localparam logic [7:0] OP_BCOND = 8'h54;
   localparam logic [7:0] OP_CBZ   = 8'hB4;
   typedef enum logic [3:0] {
      EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
   } cond_t;
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;
   typedef enum logic {RUN, HOLD} state_t;
endpackage

// File: rtl/branch_resolver_if.sv
// branch_resolver_if: fetch-side signals exchanged with the ID-stage branch resolver
interface branch_resolver_if import branch_pkg::*; #(parameter int CNT_W = 16);
   logic [31:0]      instr;
   logic             flags_wr;
   nzcv_t            alu_flags;
   logic [63:0]      cbz_val;
   logic             cbz_val_valid;
   logic [31:0]      id_instr;
   logic [25:0]      imm26;
   logic [18:0]      imm19;
   logic             uncondBr;
   logic             brTaken;
   logic             pc_hold;
   nzcv_t            flags;
   logic [CNT_W-1:0] taken_count;
   modport master (
      output instr, flags_wr, alu_flags, cbz_val, cbz_val_valid,
      input  id_instr, imm26, imm19, uncondBr, brTaken, pc_hold, flags, taken_count
   );
   modport slave (
      input  instr, flags_wr, alu_flags, cbz_val, cbz_val_valid,
      output id_instr, imm26, imm19, uncondBr, brTaken, pc_hold, flags, taken_count
   );
endinterface

// File: rtl/branch_resolver_cond_eval.sv
// cond_eval: evaluates an AArch64 condition code against NZCV flags
module cond_eval import branch_pkg::*; (
   input  cond_t cond_i,
   input  nzcv_t flags_i,
   output logic  taken_o
);
   logic base;
   // Odd codes are the negation of the even code below them, except 1111 which is always true
   always_comb begin
      case (cond_i[3:1])
         3'b000:  base = flags_i.z;
         3'b001:  base = flags_i.c;
         3'b010:  base = flags_i.n;
         3'b011:  base = flags_i.v;
         3'b100:  base = flags_i.c & ~flags_i.z;
         3'b101:  base = flags_i.n == flags_i.v;
         3'b110:  base = ~flags_i.z & (flags_i.n == flags_i.v);
         default: base = 1'b1;
      endcase
      taken_o = (cond_i[0] && cond_i[3:1] != 3'b111) ? ~base : base;
   end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: IF/ID register, branch decode, NZCV register, CBZ stall and taken-branch counter
module branch_resolver import branch_pkg::*; #(
   parameter int          CNT_W     = 16,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input logic              clk,
   input logic              reset,
   branch_resolver_if.slave bus
);
   logic [31:0]      id_q, id_d;
   nzcv_t            flags_q, flags_d, eff;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_b, is_bcond, is_cbz, cond_ok, cbz_zero, hold, taken;
   assign is_b     = id_q[31:26] == OP_B;
   assign is_bcond = id_q[31:24] == OP_BCOND;
   assign is_cbz   = id_q[31:24] == OP_CBZ;
   assign cbz_zero = bus.cbz_val == 64'd0;
   assign eff      = bus.flags_wr ? bus.alu_flags : flags_q;
   cond_eval u_cond (
      .cond_i  (cond_t'(id_q[3:0])),
      .flags_i (eff),
      .taken_o (cond_ok)
   );
   // Stall while a CBZ operand is unavailable; the resolve cycle releases the hold
   always_comb begin
      state_d = state_q;
      hold    = 1'b0;
      if (state_q == RUN) begin
         if (is_cbz && !bus.cbz_val_valid) begin
            hold    = 1'b1;
            state_d = HOLD;
         end
      end else if (!bus.cbz_val_valid) begin
         hold = 1'b1;
      end else begin
         state_d = RUN;
      end
   end
   // Redirect, IF/ID advance, flag update and saturating count
   always_comb begin
      taken   = !hold && (is_b || (is_bcond && cond_ok) || (is_cbz && cbz_zero));
      id_d    = hold ? id_q : bus.instr;
      flags_d = bus.flags_wr ? bus.alu_flags : flags_q;
      cnt_d   = (taken && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   // Pipeline and architectural state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         id_q    <= NOP_INSTR;
         flags_q <= '0;
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         id_q    <= id_d;
         flags_q <= flags_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   assign bus.id_instr    = id_q;
   assign bus.imm26       = id_q[25:0];
   assign bus.imm19       = id_q[23:5];
   assign bus.uncondBr    = is_b;
   assign bus.brTaken     = taken;
   assign bus.pc_hold     = hold;
   assign bus.flags       = flags_q;
   assign bus.taken_count = cnt_q;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vectors with a per-cycle expected-response scoreboard
module tb_branch_resolver;
   import branch_pkg::*;
   localparam int CW = 4;
   localparam logic [31:0] I_B   = 32'h1400_0010;
   localparam logic [31:0] I_EQ  = 32'h5400_00A0;
   localparam logic [31:0] I_NE  = 32'h5400_00A1;
   localparam logic [31:0] I_GT  = 32'h5400_000C;
   localparam logic [31:0] I_CBZ = 32'hB400_0043;
   localparam logic [31:0] I_ALU = 32'h1111_1111;
   typedef struct {
      logic [31:0]   id;
      logic          br;
      logic          hold;
      logic          unc;
      logic [3:0]    fl;
      logic [CW-1:0] cnt;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   branch_resolver_if #(.CNT_W(CW)) bus ();
   branch_resolver #(.CNT_W(CW), .NOP_INSTR(32'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask
   task automatic step(input logic rst, input logic [31:0] ins, input logic fw, input logic [3:0] af,
                       input logic cvv, input logic [63:0] cv,
                       input logic [31:0] e_id, input logic e_br, input logic e_hold, input logic e_unc,
                       input logic [3:0] e_fl, input logic [CW-1:0] e_cnt);
      exp_t e;
      @(posedge clk);
      #1;
      reset             = rst;
      bus.instr         = ins;
      bus.flags_wr      = fw;
      bus.alu_flags     = af;
      bus.cbz_val_valid = cvv;
      bus.cbz_val       = cv;
      e = '{e_id, e_br, e_hold, e_unc, e_fl, e_cnt};
      sb.push_back(e);
   endtask
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [31:0] eid;
         e = sb.pop_front();
         eid = e.id;
         chk("id_instr", bus.id_instr, eid);
         chk("imm26", bus.imm26, eid[25:0]);
         chk("imm19", bus.imm19, eid[23:5]);
         chk("brTaken", bus.brTaken, e.br);
         chk("pc_hold", bus.pc_hold, e.hold);
         chk("uncondBr", bus.uncondBr, e.unc);
         chk("flags", bus.flags, e.fl);
         chk("taken_count", bus.taken_count, e.cnt);
      end
   end
   initial begin
      bus.instr = I_B;
      bus.flags_wr = 1'b0;
      bus.alu_flags = '0;
      bus.cbz_val = '0;
      bus.cbz_val_valid = 1'b1;
      // reset held, B waiting at fetch
      step(0, I_B,   0, 4'b0000, 1, 0,  32'h0, 0, 0, 0, 4'b0000, 0);
      step(0, I_B,   0, 4'b0000, 1, 0,  32'h0, 0, 0, 0, 4'b0000, 0);
      step(1, I_B,   0, 4'b0000, 1, 0,  32'h0, 0, 0, 0, 4'b0000, 0);
      step(1, I_EQ,  0, 4'b0000, 1, 0,  I_B,   1, 0, 1, 4'b0000, 0);
      // B.EQ taken purely through same-cycle forwarding of Z
      step(1, I_NE,  1, 4'b0100, 1, 0,  I_EQ,  1, 0, 0, 4'b0000, 1);
      step(1, I_GT,  0, 4'b0000, 1, 0,  I_NE,  0, 0, 0, 4'b0100, 2);
      step(1, I_GT,  1, 4'b1000, 1, 0,  I_GT,  0, 0, 0, 4'b0100, 2);
      step(1, I_CBZ, 1, 4'b1001, 1, 0,  I_GT,  1, 0, 0, 4'b1000, 2);
      // CBZ stalls two cycles, flags still written during HOLD
      step(1, I_ALU, 0, 4'b0000, 0, 0,  I_CBZ, 0, 1, 0, 4'b1001, 3);
      step(1, I_ALU, 1, 4'b0010, 0, 0,  I_CBZ, 0, 1, 0, 4'b1001, 3);
      step(1, I_ALU, 0, 4'b0000, 1, 0,  I_CBZ, 1, 0, 0, 4'b0010, 3);
      step(1, I_CBZ, 0, 4'b0000, 1, 7,  I_ALU, 0, 0, 0, 4'b0010, 4);
      // CBZ with valid nonzero operand: not taken, no stall
      step(1, I_B,   0, 4'b0000, 1, 7,  I_CBZ, 0, 0, 0, 4'b0010, 4);
      // 17 back-to-back B instructions drive the counter into saturation
      for (int k = 0; k < 17; k++)
         step(1, I_B, 0, 4'b0000, 1, 0, I_B, 1, 0, 1, 4'b0010, (4 + k > 15) ? CW'(15) : CW'(4 + k));
      step(1, I_CBZ, 0, 4'b0000, 1, 0,  I_B,   1, 0, 1, 4'b0010, 15);
      step(1, I_ALU, 0, 4'b0000, 0, 0,  I_CBZ, 0, 1, 0, 4'b0010, 15);
      step(1, I_ALU, 0, 4'b0000, 0, 0,  I_CBZ, 0, 1, 0, 4'b0010, 15);
      // reset dropped mid-HOLD between edges takes effect immediately
      step(0, I_B,   0, 4'b0000, 0, 0,  32'h0, 0, 0, 0, 4'b0000, 0);
      step(1, I_B,   0, 4'b0000, 0, 0,  32'h0, 0, 0, 0, 4'b0000, 0);
      step(1, I_ALU, 0, 4'b0000, 0, 0,  I_B,   1, 0, 1, 4'b0000, 0);
      for (int w = 0; w < 4 && sb.size() > 0; w++) @(posedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
